btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//   Front-end for the LED counter's BTN[1:0] inputs: synchronizes raw board buttons to CLK (12 MHz),
//   debounces each one, and emits clean level, press, release and long-press strobes. Sits between
//   the board pins and led_counter, which consumes only the single-cycle strobes. Channels are independent.
// PARAMETERS
//   N_BTN            2        number of button channels
//   SYNC_STAGES      2        flip-flops in each input synchronizer (>=2)
//   DEBOUNCE_CYCLES  120000   consecutive stable cycles needed to accept a change (10 ms @ 12 MHz; >=1)
//   LONG_CYCLES      12000000 cycles a debounced press must be held to raise BTN_LONG (1 s; > DEBOUNCE_CYCLES)
// PORTS
//   CLK          in   1      system clock, 12 MHz
//   RST_N        in   1      asynchronous active-low reset
//   BTN_RAW      in   N_BTN  raw button pins, active-high, asynchronous to CLK
//   BTN_LEVEL    out  N_BTN  debounced button state, 1 = pressed
//   BTN_PRESS    out  N_BTN  1-cycle strobe on an accepted 0->1 of BTN_LEVEL
//   BTN_RELEASE  out  N_BTN  1-cycle strobe on an accepted 1->0 of BTN_LEVEL
//   BTN_LONG     out  N_BTN  1-cycle strobe, once per press, when the hold reaches LONG_CYCLES
// BEHAVIOUR
//   Clock and reset: a single clock; reset is asynchronous and active-low.
//   Reset: synchronizer flops, debounce counters, hold counters, state = RELEASED and all outputs = 0.
//   Synchronizer: an SYNC_STAGES-deep flop chain per bit. sync = last stage. No logic between stages.
//   Debounce, per channel:
//   - Counter db_cnt has width $clog2(DEBOUNCE_CYCLES+1).
//   - Cycle with sync == BTN_LEVEL: db_cnt <= 0.
//   - Cycle with sync != BTN_LEVEL: db_cnt increments.
//   - If db_cnt == DEBOUNCE_CYCLES-1 on that cycle, the change is accepted: BTN_LEVEL <= sync and db_cnt <= 0.
//   - Result: a raw change held steady is reflected on BTN_LEVEL after exactly SYNC_STAGES+DEBOUNCE_CYCLES
//     edges, counted from the first edge that samples the new raw value.
//   - Any glitch shorter than DEBOUNCE_CYCLES is fully rejected and produces no strobe.
//   FSM, per channel (registered outputs; strobes assert in the same cycle BTN_LEVEL changes):
//   - RELEASED: on an accepted rise -> PRESSED; BTN_PRESS=1; hold_cnt <= 0.
//   - PRESSED: hold_cnt increments every cycle.
//     - Accepted fall -> RELEASED with BTN_RELEASE=1 (no LONG).
//     - Else when hold_cnt == LONG_CYCLES-1 -> HELD with BTN_LONG=1.
//   - HELD: hold_cnt frozen. Accepted fall -> RELEASED with BTN_RELEASE=1.
//   - hold_cnt has width $clog2(LONG_CYCLES+1) and never wraps.
//   - If the fall is accepted on the same cycle hold_cnt reaches LONG_CYCLES-1, the fall wins:
//     RELEASE=1, LONG=0.
//   - Strobes are never asserted for more than 1 cycle. PRESS, RELEASE and LONG of one channel are mutually exclusive.
//   Simultaneous events: channels share nothing. Both buttons changing together yield strobes on the same
//   cycle in both bits.
//   Reset mid-operation: everything returns to the reset state immediately.
//   - A button still held when RST_N deasserts is reported as a fresh press after
//     SYNC_STAGES+DEBOUNCE_CYCLES cycles.
//   - A press in progress before reset never produces a RELEASE.
//   Boundary: DEBOUNCE_CYCLES=1 means acceptance on the first differing sync sample.
// TESTING (sim params: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, SYNC_STAGES=2)
//   1 Reset: RST_N=0 with BTN_RAW=2'b11 -> all outputs 0. Release reset -> BTN_PRESS=2'b11 exactly
//     6 cycles later, BTN_LEVEL=2'b11 from the same cycle.
//   2 Bounce: BTN_RAW[0] toggles 1,0,1,0 at 2-cycle intervals, then holds 1 -> only one BTN_PRESS[0],
//     6 cycles after the final rise. A 3-cycle pulse on BTN_RAW[1] -> no strobe, BTN_LEVEL[1] stays 0.
//   3 Short press: BTN_RAW[0] high for 12 cycles -> PRESS[0] once, RELEASE[0] once 12 cycles later,
//     LONG[0] never.
//   4 Long press: BTN_RAW[1] held for 40 cycles -> PRESS[1]; LONG[1] 20 cycles after PRESS;
//     RELEASE[1] after the raw fall + 6 cycles. No second LONG.
//   5 Race: raw fall timed so the fall is accepted on the cycle hold_cnt==19 -> RELEASE=1, LONG=0.
//     Independently, both channels pressed together -> PRESS=2'b11 on one cycle.
//   6 Async reset mid-hold: assert RST_N for 1 ns between edges while in HELD -> outputs 0 immediately,
//     no RELEASE. On deassert with the button still held -> fresh PRESS after 6 cycles.

Source files
------------

// File: rtl/btn_conditioner.sv
// Button front-end: per-channel synchronizer, counter debouncer and press/release/long-press FSM.
// Every channel is an independent copy; all outputs are registered.
`timescale 1ns/1ps
module btn_conditioner #(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned LONG_CYCLES     = 12000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o,
  output logic [N_BTN-1:0] btn_long_o
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESSED,
    ST_HELD
  } state_e;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   accept;
    state_e                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   long_q, long_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i[g]};
      end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // A change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      accept   = 1'b0;
      if (sync == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_cnt_d = '0;
        level_d  = sync;
        accept   = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
      unique case (state_q)
        ST_RELEASED: begin
          if (accept && level_d) begin
            state_d    = ST_PRESSED;
            press_d    = 1'b1;
            hold_cnt_d = '0;
          end
        end
        ST_PRESSED: begin
          // A fall accepted on the same cycle the hold matures takes priority over LONG.
          if (accept && !level_d) begin
            state_d   = ST_RELEASED;
            release_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if (hold_cnt_q == HOLD_LAST) begin
              state_d = ST_HELD;
              long_d  = 1'b1;
            end
          end
        end
        ST_HELD: begin
          if (accept && !level_d) begin
            state_d   = ST_RELEASED;
            release_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_RELEASED;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q   <= '0;
        level_q    <= 1'b0;
        state_q    <= ST_RELEASED;
        hold_cnt_q <= '0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
      end else begin
        db_cnt_q   <= db_cnt_d;
        level_q    <= level_d;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        press_q    <= press_d;
        release_q  <= release_d;
        long_q     <= long_d;
      end
    end

    assign btn_level_o[g]   = level_q;
    assign btn_press_o[g]   = press_q;
    assign btn_release_o[g] = release_q;
    assign btn_long_o[g]    = long_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/long-press counts.
// Per-cycle vector table plus hand sequences for the release/long race and async reset.
`timescale 1ns/1ps
module tb_btn_conditioner;

  localparam int N_BTN = 2;
  localparam int SYNC  = 2;
  localparam int DB    = 4;
  localparam int LONG  = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;

  btn_conditioner #(
    .N_BTN          (N_BTN),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw_i    (btn_raw),
    .btn_level_o  (btn_level),
    .btn_press_o  (btn_press),
    .btn_release_o(btn_release),
    .btn_long_o   (btn_long)
  );

  always #5 clk = ~clk;

  // One record per clock: raw is applied before the edge, outputs are expected after it.
  typedef struct {
    string      tag;
    logic [1:0] raw;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(input string tag, input logic [1:0] raw, input logic [1:0] level,
                              input logic [1:0] press, input logic [1:0] rel,
                              input logic [1:0] lng, input int n);
    vec_t v;
    v.tag   = tag;
    v.raw   = raw;
    v.level = level;
    v.press = press;
    v.rel   = rel;
    v.lng   = lng;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [1:0] level, input logic [1:0] press,
                            input logic [1:0] rel, input logic [1:0] lng);
    check({name, ".level"},   btn_level,   level);
    check({name, ".press"},   btn_press,   press);
    check({name, ".release"}, btn_release, rel);
    check({name, ".long"},    btn_long,    lng);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Channel 0 held for high_recs cycles; long_at/rel_at are the cycles the strobes must fire (0 = never).
  task automatic race_seq(input string tag, input int high_recs, input int long_at, input int rel_at);
    logic [1:0] e_level;
    for (int i = 1; i <= rel_at + 2; i++) begin
      btn_raw = (i <= high_recs) ? 2'b01 : 2'b00;
      step();
      e_level = (i >= 6 && i < rel_at) ? 2'b01 : 2'b00;
      check_outs($sformatf("%s[%0d]", tag, i), e_level,
                 (i == 6) ? 2'b01 : 2'b00,
                 (i == rel_at) ? 2'b01 : 2'b00,
                 (i == long_at) ? 2'b01 : 2'b00);
    end
  endtask

  initial begin
    // Reset with both buttons already held: fresh press on both, 6 edges after release of reset.
    add("rst_press", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 5);
    add("rst_press", 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1);
    add("rst_press", 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1);
    add("rst_rel",   2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 5);
    add("rst_rel",   2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1);
    add("idle",      2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    // Bounce on ch0 (1,1,0,0,1,1,0,0 then held); 3-cycle pulse on ch1 must be rejected.
    add("bounce", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    add("bounce", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add("bounce", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add("bounce", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    add("bounce", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    add("bounce", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 5);
    add("bounce", 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    add("bounce", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1);
    add("bounce", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add("bounce", 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1);
    add("idle",   2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    // Short press on ch0: 12 cycles high, release 12 cycles after press, no long.
    add("short", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 5);
    add("short", 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    add("short", 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 6);
    add("short", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add("short", 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1);
    add("idle",  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    // Long press on ch1: 40 cycles high, long 20 after press, single long only.
    add("long", 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 5);
    add("long", 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 1);
    add("long", 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 19);
    add("long", 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 1);
    add("long", 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 14);
    add("long", 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 5);
    add("long", 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1);
    add("idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);

    rst_n   = 1'b0;
    btn_raw = 2'b11;
    repeat (3) step();
    check_outs("in_reset", 2'b00, 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      btn_raw = vecs[i].raw;
      step();
      check_outs($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].level, vecs[i].press,
                 vecs[i].rel, vecs[i].lng);
    end

    // Fall accepted exactly when the hold matures: release wins. One cycle later: long, then release.
    race_seq("race_fall_wins", 20, 0, 26);
    race_seq("race_long_first", 21, 26, 27);

    // Async reset while ch1 is in HELD, then fresh press with the button still down.
    for (int i = 1; i <= 30; i++) begin
      btn_raw = 2'b10;
      step();
      if (i == 26) check_outs("pre_rst_long", 2'b10, 2'b00, 2'b00, 2'b10);
    end
    check_outs("pre_rst_held", 2'b10, 2'b00, 2'b00, 2'b00);
    #1 rst_n = 1'b0;
    #1 check_outs("async_rst", 2'b00, 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      btn_raw = 2'b10;
      step();
      check_outs($sformatf("post_rst_press[%0d]", i), (i >= 6) ? 2'b10 : 2'b00,
                 (i == 6) ? 2'b10 : 2'b00, 2'b00, 2'b00);
    end
    for (int i = 1; i <= 7; i++) begin
      btn_raw = 2'b00;
      step();
      check_outs($sformatf("post_rst_rel[%0d]", i), (i < 6) ? 2'b10 : 2'b00, 2'b00,
                 (i == 6) ? 2'b10 : 2'b00, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
